sram: RTL and testbench



---
 rtl/sram_pkg.sv | 19 +
 rtl/sram_word.sv | 42 ++++
 rtl/sram.sv | 65 ++++++
 tb/tb_sram.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// ============================================================================
// Module : sram_pkg
// Shared widths and word/address types for the flip-flop based scratch RAM.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package sram_pkg;

  localparam int SRAM_DATA_W = 8;
  localparam int SRAM_ADDR_W = 8;
  localparam int SRAM_DEPTH  = 256;

  typedef logic [SRAM_DATA_W-1:0] sram_word_t;
  typedef logic [SRAM_ADDR_W-1:0] sram_addr_t;

endpackage

`default_nettype wire

// File: rtl/sram_word.sv
// ============================================================================
// Module : sram_word
// One storage word: load-enabled register with asynchronous active-low clear.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sram_word
  import sram_pkg::*;
#(
  parameter int DATA_W = SRAM_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out
);

  logic [DATA_W-1:0] word_d;
  logic [DATA_W-1:0] word_q;

  always_comb begin
    word_d = word_q;
    if (load) begin
      word_d = data_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_q <= '0;
    end else begin
      word_q <= word_d;
    end
  end

  assign data_out = word_q;

endmodule

`default_nettype wire

// File: rtl/sram.sv
// ============================================================================
// Module : sram
// Single-port 2**ADDR_W x DATA_W RAM in resettable flops, write-first read port.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sram
  import sram_pkg::*;
#(
  parameter int DATA_W = SRAM_DATA_W,
  parameter int ADDR_W = SRAM_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write_enable,
  input  logic [DATA_W-1:0] data_in,
  input  logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data_out
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] word_rd [DEPTH];
  logic [DATA_W-1:0] data_out_d;
  logic [DATA_W-1:0] data_out_q;

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_word
      logic load;
      assign load = write_enable && (address == ADDR_W'(i));

      sram_word #(
        .DATA_W (DATA_W)
      ) u_word (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .data_in  (data_in),
        .data_out (word_rd[i])
      );
    end
  endgenerate

  // Write-through: a write edge also presents the new data on the read port.
  always_comb begin
    data_out_d = word_rd[address];
    if (write_enable) begin
      data_out_d = data_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out_q <= '0;
    end else begin
      data_out_q <= data_out_d;
    end
  end

  assign data_out = data_out_q;

endmodule

`default_nettype wire

// File: tb/tb_sram.sv
// ============================================================================
// Module : tb_sram
// Self-checking bench for sram: vector table, scoreboard queue, reset corners.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_sram;
  import sram_pkg::*;

  logic       clk;
  logic       reset;
  logic       write_enable;
  sram_word_t data_in;
  sram_addr_t address;
  sram_word_t data_out;

  int n_checks = 0;
  int n_fail   = 0;

  sram_word_t exp_q [$];
  sram_word_t model [SRAM_DEPTH];

  typedef struct {
    logic       we;
    sram_addr_t addr;
    sram_word_t din;
    sram_word_t exp;
    string      name;
  } vec_t;

  vec_t vecs [16];

  sram #(
    .DATA_W (SRAM_DATA_W),
    .ADDR_W (SRAM_ADDR_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .write_enable (write_enable),
    .data_in      (data_in),
    .address      (address),
    .data_out     (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input sram_word_t act, input sram_word_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: data_out=0x%02h expected 0x%02h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one access at the falling edge, queue its expectation, compare after the rising edge.
  task automatic apply(input logic we, input sram_addr_t a, input sram_word_t d,
                       input sram_word_t exp, input string name);
    sram_word_t e;
    @(negedge clk);
    write_enable = we;
    address      = a;
    data_in      = d;
    exp_q.push_back(exp);
    if (we) model[a] = d;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = exp_q.pop_front();
      check(name, data_out, e);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < SRAM_DEPTH; i++) model[i] = '0;
  endtask

  initial begin
    vecs[0]  = '{1'b0, 8'h00, 8'h00, 8'h00, "rst_rd_00"};
    vecs[1]  = '{1'b0, 8'h10, 8'h00, 8'h00, "rst_rd_10"};
    vecs[2]  = '{1'b0, 8'hFF, 8'h00, 8'h00, "rst_rd_ff"};
    vecs[3]  = '{1'b1, 8'h10, 8'h55, 8'h55, "wr_10_thru"};
    vecs[4]  = '{1'b0, 8'h10, 8'h00, 8'h55, "rd_10"};
    vecs[5]  = '{1'b1, 8'h20, 8'hA5, 8'hA5, "wr_20_thru"};
    vecs[6]  = '{1'b0, 8'h10, 8'h00, 8'h55, "rd_10_again"};
    vecs[7]  = '{1'b0, 8'h30, 8'h00, 8'h00, "rd_30_blank"};
    vecs[8]  = '{1'b0, 8'h20, 8'h00, 8'hA5, "rd_20"};
    vecs[9]  = '{1'b1, 8'h00, 8'h01, 8'h01, "wr_00"};
    vecs[10] = '{1'b1, 8'hFF, 8'hFE, 8'hFE, "wr_ff"};
    vecs[11] = '{1'b0, 8'h00, 8'h00, 8'h01, "rd_00"};
    vecs[12] = '{1'b0, 8'hFF, 8'h00, 8'hFE, "rd_ff"};
    vecs[13] = '{1'b1, 8'h40, 8'h11, 8'h11, "wr_40_a"};
    vecs[14] = '{1'b1, 8'h40, 8'h22, 8'h22, "wr_40_b"};
    vecs[15] = '{1'b0, 8'h40, 8'h00, 8'h22, "rd_40"};

    clear_model();
    reset        = 1'b0;
    write_enable = 1'b0;
    data_in      = '0;
    address      = '0;
    #1;
    check("reset_state", data_out, 8'h00);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i <= 8; i++) begin
      apply(vecs[i].we, vecs[i].addr, vecs[i].din, vecs[i].exp, vecs[i].name);
    end

    // Asynchronous clear between edges, with a write attempted while held low.
    #3;
    reset = 1'b0;
    #1;
    check("async_clear", data_out, 8'h00);
    clear_model();
    @(negedge clk);
    write_enable = 1'b1;
    address      = 8'h20;
    data_in      = 8'h77;
    @(posedge clk);
    #1;
    check("wr_in_reset", data_out, 8'h00);
    @(negedge clk);
    write_enable = 1'b0;
    reset        = 1'b1;
    apply(1'b0, 8'h20, 8'hA5, 8'h00, "rd_20_cleared");
    apply(1'b0, 8'h20, 8'h00, 8'h00, "rd_20_not_written");

    for (int i = 9; i < 16; i++) begin
      apply(vecs[i].we, vecs[i].addr, vecs[i].din, vecs[i].exp, vecs[i].name);
    end

    // Walking ones across the whole array, then read everything back.
    for (int a = 0; a < SRAM_DEPTH; a++) begin
      sram_word_t w;
      w = sram_word_t'(1) << (a % SRAM_DATA_W);
      if (a >= 128) w = ~w;
      apply(1'b1, sram_addr_t'(a), w, w, "walk_wr");
    end
    for (int a = 0; a < SRAM_DEPTH; a++) begin
      apply(1'b0, sram_addr_t'(a), 8'h00, model[a], "walk_rd");
    end

    // data_out must hold between edges when inputs change mid-cycle.
    @(negedge clk);
    write_enable = 1'b0;
    address      = 8'h03;
    #2;
    check("hold_between_edges", data_out, model[8'hFF]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
